stereo_sample_queue: RTL and testbench
======================================

Name: stereo_sample_queue

Overview:
- Dual-channel circular sample queue that feeds each equalizer band FIR.
- Stores incoming left/right audio samples in a circular buffer.
- On each new sample, once the buffer holds a full window, streams the most recent TAPS samples (oldest first) to the band filters.
- Drives the `sequencing` strobe, whose rising edge restarts the filters' coefficient address and accumulators.

Parameters:
- DEPTH, 1024, buffer entries per channel; power of two; DEPTH >= TAPS+2.
- TAPS, 1021, samples streamed per readout; equals the band filter tap count.
- DW, 16, sample width (signed two's complement).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- valid  input  1  one-cycle pulse; new sample pair present on lft_smpl/rght_smpl
- lft_smpl  input  DW  left sample, captured when valid=1
- rght_smpl  input  DW  right sample, captured when valid=1
- sequencing  output  1  high for exactly TAPS consecutive cycles per readout
- lft_out  output  DW  left window sample; 0 when sequencing=0
- rght_out  output  DW  right window sample; 0 when sequencing=0
- full  output  1  high once at least TAPS samples have been written since reset

Behaviour:
- Reset (async, rst_n=0):
  - write pointer=0, fill count=0, state=IDLE, pending=0.
  - sequencing=0, lft_out=rght_out=0, full=0.
  - Buffer contents are not reset.
- Write path, independent of read state:
  - On valid=1, write the sample pair at wr_ptr; wr_ptr <= wr_ptr+1 modulo DEPTH, wrapping DEPTH-1 -> 0.
  - Fill count increments and saturates at TAPS; full = (count == TAPS).
- Readout trigger: a valid that makes or finds count == TAPS requests a readout.
  - The window start is captured at the request: start = (index just written) - TAPS + 1, modulo DEPTH.
- State machine IDLE / READ:
  - IDLE: on request, next cycle -> READ with rd_ptr=start and beat counter=0.
  - READ: sequencing=1. Each cycle outputs buffer[rd_ptr] on lft_out/rght_out, then increments rd_ptr (wrapping) and the beat counter.
  - After beat TAPS-1, -> IDLE, or directly to READ for the pending window (see below).
- Latency and alignment:
  - First sequencing cycle is the cycle after the valid cycle.
  - Beat k (k=0..TAPS-1) carries the k-th oldest sample of the window.
  - Outputs are registered and aligned with sequencing; use a synchronous-read buffer with the address issued one cycle early.
- Request during READ:
  - Set pending and capture that request's window start; the current readout is not disturbed.
  - When the current readout ends, sequencing drops for exactly one cycle (so filters see a fresh rising edge), then READ restarts with the pending window.
  - pending is one deep; a further request while pending=1 overwrites the pending start with the newer window.
- Overwrite safety: DEPTH - TAPS >= 2 guarantees writes during a readout never overwrite unread window entries, provided at most one pending request.
- Outside READ: lft_out=rght_out=0 and sequencing=0.
- Simultaneous valid on the last READ beat: treated as pending; same one-cycle gap rule applies.
- Reset mid-readout: immediate abort; all outputs 0. The next readout requires TAPS fresh writes.

Test Plan:
- Fill: write samples 1..1020 (lft=n, rght=-n), valid every 50 cycles -> sequencing never asserts; full=0.
- First window: write sample 1021 -> full=1. Next cycle sequencing rises for exactly 1021 cycles; lft_out = 1,2,...,1021 and rght_out = -1..-1021, in order. Outputs 0 after.
- Sliding and wrap: write samples up to 1030 (wr_ptr wraps past 1023) -> readout after sample 1030 streams 10..1030 contiguous, no glitch across the buffer wrap.
- Pending: valid for sample 1022 arrives 100 cycles into the 1021 readout -> first readout completes unchanged. sequencing low for 1 cycle, then a second readout of 2..1022.
- Reset mid-readout: assert rst_n=0 at beat 500 -> sequencing, outputs and full go 0 immediately. After release, 1020 writes give no readout; the 1021st starts one.
- Last-beat collision: valid coincides with final beat of a readout -> one idle cycle, then a new 1021-beat readout of the updated window.

Source files
------------

// File: rtl/stereo_sample_queue_if.sv
// Sample-in / window-out bundle between the audio front end, the sample queue and the band FIRs.
interface stereo_sample_queue_if #(
  parameter int unsigned DW = 16
);
  logic          valid;
  logic [DW-1:0] lft_smpl;
  logic [DW-1:0] rght_smpl;
  logic          sequencing;
  logic [DW-1:0] lft_out;
  logic [DW-1:0] rght_out;
  logic          full;

  modport master (
    output valid, lft_smpl, rght_smpl,
    input  sequencing, lft_out, rght_out, full
  );

  modport slave (
    input  valid, lft_smpl, rght_smpl,
    output sequencing, lft_out, rght_out, full
  );
endinterface

// File: rtl/stereo_sample_queue.sv
// Dual-channel circular sample queue: stores stereo samples and, on each new sample once a full
// window exists, streams the most recent TAPS samples oldest-first to the band filters.
module stereo_sample_queue #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned TAPS  = 1021,
  parameter int unsigned DW    = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  stereo_sample_queue_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(TAPS + 1);
  localparam int unsigned BW = $clog2(TAPS);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRead = 1'b1;

  logic [2*DW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] pstart_q, pstart_d;
  logic [DW-1:0] lft_q, rght_q;

  logic          req;
  logic [AW-1:0] start;
  logic [AW-1:0] rd_addr;
  logic          out_en;

  // A write that makes or finds the fill count at TAPS asks for a readout of the newest window.
  assign req   = bus.valid && (count_q >= CW'(TAPS - 1));
  assign start = wr_ptr_q - AW'(TAPS - 1);

  always_ff @(posedge clk) begin
    if (bus.valid) begin
      mem_q[wr_ptr_q] <= {bus.lft_smpl, bus.rght_smpl};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.valid) begin
      wr_ptr_q <= wr_ptr_q + 1'b1;
      if (count_q != CW'(TAPS)) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    beat_d   = beat_q;
    pend_d   = pend_q;
    pstart_d = pstart_q;
    rd_addr  = rd_ptr_q;
    out_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A fresh request supersedes a pending window since it is newer.
        if (req || pend_q) begin
          rd_addr  = req ? start : pstart_q;
          out_en   = 1'b1;
          state_d  = StRead;
          beat_d   = '0;
          rd_ptr_d = rd_addr + 1'b1;
          pend_d   = 1'b0;
        end
      end
      StRead: begin
        if (req) begin
          pend_d   = 1'b1;
          pstart_d = start;
        end
        if (beat_q == BW'(TAPS - 1)) begin
          state_d = StIdle;
        end else begin
          out_en   = 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
          beat_d   = beat_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rd_ptr_q <= '0;
      beat_q   <= '0;
      pend_q   <= 1'b0;
      pstart_q <= '0;
      lft_q    <= '0;
      rght_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      beat_q   <= beat_d;
      pend_q   <= pend_d;
      pstart_q <= pstart_d;
      if (out_en) begin
        {lft_q, rght_q} <= mem_q[rd_addr];
      end else begin
        lft_q  <= '0;
        rght_q <= '0;
      end
    end
  end

  assign bus.sequencing = (state_q == StRead);
  assign bus.lft_out    = lft_q;
  assign bus.rght_out   = rght_q;
  assign bus.full       = (count_q == CW'(TAPS));

endmodule

// File: tb/tb_stereo_sample_queue.sv
// Directed bench for stereo_sample_queue with a window scoreboard and run/gap length tracking.
module tb_stereo_sample_queue;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned TAPS  = 29;
  localparam int unsigned DW    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stereo_sample_queue_if #(.DW(DW)) bus ();

  stereo_sample_queue #(
    .DEPTH(DEPTH),
    .TAPS (TAPS),
    .DW   (DW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int gid   = 0;
  int hist[$];
  int sb[$];
  int runs[$];
  int gaps[$];
  bit prev_seq = 1'b0;
  bit seen = 1'b0;
  int run_cnt = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected beats of a window are the last TAPS samples written since reset, oldest first.
  task automatic write_one();
    @(posedge clk);
    #1;
    gid++;
    hist.push_back(gid);
    bus.valid     = 1'b1;
    bus.lft_smpl  = DW'(gid);
    bus.rght_smpl = DW'(-gid);
    if (hist.size() >= TAPS) begin
      for (int i = hist.size() - TAPS; i < hist.size(); i++) sb.push_back(hist[i]);
    end
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((bus.sequencing || sb.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk(tag, sb.size(), 0);
  endtask

  task automatic clear_track();
    runs.delete();
    gaps.delete();
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_seq = 1'b0;
      seen     = 1'b0;
      run_cnt  = 0;
    end else begin
      if (bus.sequencing) begin
        if (sb.size() == 0) begin
          chk("unexpected_seq", 1, 0);
        end else begin
          int e;
          e = sb.pop_front();
          chk("lft_out", int'($signed(bus.lft_out)), e);
          chk("rght_out", int'($signed(bus.rght_out)), -e);
        end
      end else begin
        chk("idle_out", int'({bus.lft_out, bus.rght_out}), 0);
      end
      if (bus.sequencing != prev_seq) begin
        if (prev_seq) runs.push_back(run_cnt);
        else if (seen) gaps.push_back(run_cnt);
        run_cnt = 1;
        seen    = 1'b1;
      end else begin
        run_cnt++;
      end
      prev_seq = bus.sequencing;
    end
  end

  initial begin
    bus.valid     = 1'b0;
    bus.lft_smpl  = '0;
    bus.rght_smpl = '0;
    #1;
    chk("rst_seq", int'(bus.sequencing), 0);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_out", int'({bus.lft_out, bus.rght_out}), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill to one short of a window: nothing streams.
    for (int i = 0; i < TAPS - 1; i++) begin
      write_one();
      repeat (4) @(posedge clk);
    end
    @(negedge clk);
    chk("fill_full", int'(bus.full), 0);
    chk("fill_seq", int'(bus.sequencing), 0);

    // First window: starts the cycle after the valid.
    clear_track();
    write_one();
    @(negedge clk);
    chk("first_full", int'(bus.full), 1);
    chk("first_latency", int'(bus.sequencing), 1);
    drain("first_drain");
    chk("first_runs", runs.size(), 1);
    chk("first_len", runs[0], TAPS);

    // Request mid-readout is held pending, then replayed after a one-cycle gap.
    clear_track();
    write_one();
    repeat (10) @(posedge clk);
    write_one();
    drain("pend_drain");
    chk("pend_runs", runs.size(), 2);
    chk("pend_len0", runs[0], TAPS);
    chk("pend_len1", runs[1], TAPS);
    chk("pend_gap", gaps[gaps.size() - 1], 1);

    // Sliding windows across the buffer wrap.
    while (gid < 40) begin
      write_one();
      repeat (35) @(posedge clk);
    end
    drain("wrap_drain");

    // Valid on the final beat of a readout.
    clear_track();
    write_one();
    repeat (TAPS - 2) @(posedge clk);
    write_one();
    drain("coll_drain");
    chk("coll_runs", runs.size(), 2);
    chk("coll_len1", runs[1], TAPS);
    chk("coll_gap", gaps[gaps.size() - 1], 1);

    // Reset mid-readout aborts immediately and needs a full refill.
    write_one();
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_seq", int'(bus.sequencing), 0);
    chk("abort_full", int'(bus.full), 0);
    chk("abort_out", int'({bus.lft_out, bus.rght_out}), 0);
    sb.delete();
    hist.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < TAPS - 1; i++) begin
      write_one();
      repeat (2) @(posedge clk);
    end
    @(negedge clk);
    chk("refill_full", int'(bus.full), 0);
    clear_track();
    write_one();
    @(negedge clk);
    chk("refill_start", int'(bus.sequencing), 1);
    drain("refill_drain");
    chk("refill_len", runs[0], TAPS);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
